// File: rtl/spi_pkg.sv
// Shared types and constants for the byte-oriented SPI master.
// Register bundle and FSM encoding live here so the top stays a single next-state block.
package spi_pkg;

    localparam int unsigned SPI_BITS  = 8;
    localparam logic        MOSI_IDLE = 1'b1;

    typedef enum logic [2:0] {
        SPI_IDLE  = 3'd0,
        SPI_SETUP = 3'd1,
        SPI_HIGH  = 3'd2,
        SPI_LOW   = 3'd3,
        SPI_NEXT  = 3'd4,
        SPI_HOLD  = 3'd5,
        SPI_GAP   = 3'd6
    } spi_state_e;

    typedef struct packed {
        logic [2:0]          state;
        logic [2:0]          bit_idx;
        logic [SPI_BITS-1:0] tx_shift;
        logic                tx_last;
        logic [SPI_BITS-1:0] rx_shift;
        logic [SPI_BITS-1:0] rx_data;
        logic                rx_valid;
        logic                busy;
        logic                sclk;
        logic                cs;
        logic                mosi;
    } spi_regs_t;

    localparam spi_regs_t SPI_REGS_RST = '{
        state:    SPI_IDLE,
        bit_idx:  3'd0,
        tx_shift: '0,
        tx_last:  1'b0,
        rx_shift: '0,
        rx_data:  '0,
        rx_valid: 1'b0,
        busy:     1'b0,
        sclk:     1'b0,
        cs:       1'b1,
        mosi:     MOSI_IDLE
    };

endpackage

// File: rtl/spi_master_if.sv
// Byte-stream side of the SPI master: tx handshake, rx result and busy.
// 'master' is the byte producer/consumer; 'slave' is the spi_master block itself.
interface spi_master_if;
    import spi_pkg::*;

    logic [SPI_BITS-1:0] tx_data;
    logic                tx_last;
    logic                tx_valid;
    logic                tx_ready;
    logic [SPI_BITS-1:0] rx_data;
    logic                rx_valid;
    logic                busy;

    modport master (
        output tx_data, tx_last, tx_valid,
        input  tx_ready, rx_data, rx_valid, busy
    );

    modport slave (
        input  tx_data, tx_last, tx_valid,
        output tx_ready, rx_data, rx_valid, busy
    );

endinterface

// File: rtl/spi_half_tick.sv
// Loadable 8-bit down-counter timing SCLK half-periods; tick_o is high while the count sits at 0.
// Reloading on every FSM transition makes each state last load_val_i+1 cycles.
module spi_half_tick (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    output logic       tick_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        // NOTE: assign every always_comb output a default first so no path infers a latch.
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == 8'd0);

endmodule

// File: rtl/spi_master.sv
// Byte-oriented SPI master: LSB first, SCLK idles low, MOSI changes on the rise, both ends sample on the fall.
// CS stays low across consecutive bytes until a byte tagged tx_last has been shifted.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    spi_master_if.slave bus,
    output logic        sclk_o,
    output logic        cs_o,
    output logic        mosi_o,
    input  logic        miso_i
);

    localparam logic [2:0] ST_IDLE  = SPI_IDLE;
    localparam logic [2:0] ST_SETUP = SPI_SETUP;
    localparam logic [2:0] ST_HIGH  = SPI_HIGH;
    localparam logic [2:0] ST_LOW   = SPI_LOW;
    localparam logic [2:0] ST_NEXT  = SPI_NEXT;
    localparam logic [2:0] ST_HOLD  = SPI_HOLD;
    localparam logic [2:0] ST_GAP   = SPI_GAP;

    localparam logic [7:0] HALF_LOAD = 8'(DIV - 1);
    localparam logic [2:0] LAST_BIT  = 3'(SPI_BITS - 1);

    spi_regs_t regs_q;
    spi_regs_t regs_d;
    logic      tick;
    logic      load;
    logic      tx_ready;
    logic      accept;

    spi_half_tick u_half_tick (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .load_val_i (HALF_LOAD),
        .tick_o     (tick)
    );

    // A byte can only be taken in IDLE or between bytes of an unfinished transaction.
    assign tx_ready = (regs_q.state == ST_IDLE) ||
                      ((regs_q.state == ST_NEXT) && !regs_q.tx_last);
    assign accept   = bus.tx_valid && tx_ready;
    assign load     = (regs_d.state != regs_q.state);

    always_comb begin
        regs_d          = regs_q;
        regs_d.rx_valid = 1'b0;

        unique case (regs_q.state)
            ST_IDLE: begin
                if (accept) begin
                    regs_d.tx_shift = bus.tx_data;
                    regs_d.tx_last  = bus.tx_last;
                    regs_d.bit_idx  = 3'd0;
                    regs_d.cs       = 1'b0;
                    regs_d.busy     = 1'b1;
                    regs_d.state    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    regs_d.sclk  = 1'b1;
                    regs_d.mosi  = regs_q.tx_shift[regs_q.bit_idx];
                    regs_d.state = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (tick) begin
                    regs_d.sclk                      = 1'b0;
                    regs_d.rx_shift[regs_q.bit_idx] = miso_i;
                    regs_d.state                     = ST_LOW;
                end
            end
            ST_LOW: begin
                if (tick) begin
                    if (regs_q.bit_idx != LAST_BIT) begin
                        regs_d.bit_idx = regs_q.bit_idx + 3'd1;
                        regs_d.sclk    = 1'b1;
                        regs_d.mosi    = regs_q.tx_shift[regs_q.bit_idx + 3'd1];
                        regs_d.state   = ST_HIGH;
                    end else begin
                        regs_d.rx_data  = regs_q.rx_shift;
                        regs_d.rx_valid = 1'b1;
                        regs_d.state    = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                // Waits here indefinitely with CS low until the next byte arrives.
                if (regs_q.tx_last) begin
                    regs_d.state = ST_HOLD;
                end else if (accept) begin
                    regs_d.tx_shift = bus.tx_data;
                    regs_d.tx_last  = bus.tx_last;
                    regs_d.bit_idx  = 3'd0;
                    regs_d.sclk     = 1'b1;
                    regs_d.mosi     = bus.tx_data[0];
                    regs_d.state    = ST_HIGH;
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    regs_d.cs    = 1'b1;
                    regs_d.state = ST_GAP;
                end
            end
            ST_GAP: begin
                if (tick) begin
                    regs_d.busy  = 1'b0;
                    regs_d.mosi  = MOSI_IDLE;
                    regs_d.state = ST_IDLE;
                end
            end
            default: begin
                regs_d = SPI_REGS_RST;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q <= SPI_REGS_RST;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign bus.tx_ready = tx_ready;
    assign bus.rx_data  = regs_q.rx_data;
    assign bus.rx_valid = regs_q.rx_valid;
    assign bus.busy     = regs_q.busy;
    assign sclk_o       = regs_q.sclk;
    assign cs_o         = regs_q.cs;
    assign mosi_o       = regs_q.mosi;

endmodule
